aes_key_loader: RTL and testbench

//  Bus initiator that provisions AES key slots. On a load request it snapshots one 192-bit key

---
 rtl/aes_key_loader_pkg.sv | 38 +++
 rtl/aes_key_loader_timeout.sv | 37 +++
 rtl/aes_key_loader.sv | 160 ++++++++++++++++
 tb/tb_aes_key_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_loader_pkg.sv
// Shared constants, state encoding and key-slot address map for the AES key loader.
// The AES_KEY_LOADER_READBACK_EN build option uses the RB_* states declared here.
package aes_key_loader_pkg;

  localparam int unsigned NumKeys       = 3;
  localparam int unsigned KeyWords      = 6;
  localparam int unsigned WordWidth     = 32;
  localparam int unsigned AddrWidth     = 64;
  localparam int unsigned TimeoutCycles = 256;
  localparam int unsigned SelWidth      = 2;
  localparam int unsigned WordIdxWidth  = $clog2(KeyWords);
  localparam int unsigned KeyBits       = KeyWords * WordWidth;

  localparam logic [AddrWidth-1:0] AesBase = 64'h0000_0000_1010_0000;

  // Each slot's key registers start at a fixed word offset inside the AES block.
  localparam logic [AddrWidth-1:0] KeySlotBase [NumKeys] = '{
    AesBase + 64'd20,
    AesBase + 64'd80,
    AesBase + 64'd104
  };

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RESP    = 3'd2,
    RB_REQ  = 3'd3,
    RB_RESP = 3'd4,
    FIN     = 3'd5,
    ABORT   = 3'd6
  } state_e;

  function automatic logic [AddrWidth-1:0] word_addr(input logic [AddrWidth-1:0] base,
                                                     input logic [WordIdxWidth-1:0] word);
    return base + AddrWidth'({word, 2'b00});
  endfunction

endpackage

// File: rtl/aes_key_loader_timeout.sv
// Response watchdog: loaded when a transaction is granted, counts cycles spent waiting
// for the response and flags expiry once the budget is used up.
module aes_key_loader_timeout #(
  parameter int unsigned Cycles = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntWidth = $clog2(Cycles + 1);

  logic [CntWidth-1:0] count_reg;
  logic                armed_reg;

  // Loaded with Cycles-1 so that expiry is seen on the Cycles-th waiting cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else if (load_i) begin
      count_reg <= CntWidth'(Cycles - 1);
      armed_reg <= 1'b1;
    end else if (clear_i) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else if (en_i && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire_o = armed_reg && (count_reg == '0);

endmodule

// File: rtl/aes_key_loader.sv
// Bus initiator that copies one 192-bit key from the key store into an AES key slot.
// Define AES_KEY_LOADER_READBACK_EN to verify every written word with a read-back.
module aes_key_loader
  import aes_key_loader_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                load_req_i,
  input  logic [SelWidth-1:0]                 load_sel_i,
  input  logic [NumKeys*KeyWords*WordWidth-1:0] key_data_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  output logic                                bus_req_o,
  input  logic                                bus_gnt_i,
  output logic                                bus_we_o,
  output logic [AddrWidth-1:0]                bus_addr_o,
  output logic [WordWidth-1:0]                bus_wdata_o,
  output logic [3:0]                          bus_be_o,
  input  logic                                bus_rvalid_i,
  input  logic [WordWidth-1:0]                bus_rdata_i,
  input  logic                                bus_err_i
);

  localparam logic [WordIdxWidth-1:0] LastWord = WordIdxWidth'(KeyWords - 1);

  state_e                                  state_reg, state_next;
  logic [WordIdxWidth-1:0]                 word_reg, word_next;
  logic [KeyWords-1:0][WordWidth-1:0]      key_reg;
  logic [AddrWidth-1:0]                    base_reg;
  logic [KeyWords-1:0][WordWidth-1:0]      slot_bits [NumKeys];
  logic                                    sel_ok;
  logic                                    load_accept;
  logic                                    to_load;
  logic                                    to_en;
  logic                                    to_clear;
  logic                                    to_expire;

  for (genvar gi = 0; gi < NumKeys; gi++) begin : g_slot
    assign slot_bits[gi] = key_data_i[gi*KeyBits +: KeyBits];
  end

  assign sel_ok      = (load_sel_i < SelWidth'(NumKeys));
  assign load_accept = (state_reg == IDLE) && load_req_i && sel_ok;

  // The whole key is snapshotted at acceptance so key store updates cannot tear a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      base_reg  <= '0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      if (load_accept) begin
        base_reg <= KeySlotBase[load_sel_i];
        key_reg  <= slot_bits[load_sel_i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    to_load    = 1'b0;
    to_en      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (load_req_i) begin
          word_next  = '0;
          state_next = sel_ok ? REQ : ABORT;
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          to_load    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            state_next = ABORT;
          end else begin
`ifdef AES_KEY_LOADER_READBACK_EN
            state_next = RB_REQ;
`else
            if (word_reg == LastWord) begin
              state_next = FIN;
            end else begin
              word_next  = word_reg + 1'b1;
              state_next = REQ;
            end
`endif
          end
        end else begin
          to_en = 1'b1;
          if (to_expire) state_next = ABORT;
        end
      end
`ifdef AES_KEY_LOADER_READBACK_EN
      RB_REQ: begin
        if (bus_gnt_i) begin
          to_load    = 1'b1;
          state_next = RB_RESP;
        end
      end
      RB_RESP: begin
        if (bus_rvalid_i) begin
          if (bus_err_i || (bus_rdata_i != key_reg[word_reg])) begin
            state_next = ABORT;
          end else if (word_reg == LastWord) begin
            state_next = FIN;
          end else begin
            word_next  = word_reg + 1'b1;
            state_next = REQ;
          end
        end else begin
          to_en = 1'b1;
          if (to_expire) state_next = ABORT;
        end
      end
`endif
      FIN:     state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign to_clear = (state_reg == IDLE);

  aes_key_loader_timeout #(
    .Cycles(TimeoutCycles)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (to_load),
    .clear_i (to_clear),
    .en_i    (to_en),
    .expire_o(to_expire)
  );

`ifndef AES_KEY_LOADER_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^bus_rdata_i;
`endif

  // Outputs decode straight from state so an async reset clears them immediately.
  assign busy_o      = (state_reg == REQ) || (state_reg == RESP) ||
                       (state_reg == RB_REQ) || (state_reg == RB_RESP);
  assign done_o      = (state_reg == FIN);
  assign err_o       = (state_reg == ABORT);
  assign bus_req_o   = (state_reg == REQ) || (state_reg == RB_REQ);
  assign bus_we_o    = (state_reg == REQ);
  assign bus_addr_o  = bus_req_o ? word_addr(base_reg, word_reg) : '0;
  assign bus_wdata_o = (state_reg == REQ) ? key_reg[word_reg] : '0;
  assign bus_be_o    = bus_req_o ? 4'hF : 4'h0;

endmodule

// File: tb/tb_aes_key_loader.sv
// Directed-plus-random bench for aes_key_loader with a transaction-level bus responder
// and a cycle-count/transaction-list reference model.
`timescale 1ns/1ps
module tb_aes_key_loader;

  localparam int NK = 3;
  localparam int KW = 6;
  localparam int TO = 256;
`ifdef AES_KEY_LOADER_READBACK_EN
  localparam int TPW = 2;
`else
  localparam int TPW = 1;
`endif
  localparam logic [63:0] AES_BASE = 64'h0000_0000_1010_0000;

  int slot_off [NK] = '{5, 20, 26};

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 load_req_i = 1'b0;
  logic [1:0]           load_sel_i = 2'd0;
  logic [NK*KW*32-1:0]  key_data_i = '0;
  logic                 busy_o, done_o, err_o;
  logic                 bus_req_o, bus_we_o;
  logic [63:0]          bus_addr_o;
  logic [31:0]          bus_wdata_o;
  logic [3:0]           bus_be_o;
  logic                 bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [31:0]          bus_rdata_i;

  aes_key_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_req_i(load_req_i), .load_sel_i(load_sel_i),
    .key_data_i(key_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  logic [31:0] keys [NK][KW];

  // responder knobs (absolute transaction indices)
  int gnt_wait_txn = -1;
  int gnt_wait_cycles = 0;
  int err_txn = -1;
  int corrupt_txn = -1;
  int resp_delay = 0;

  logic        we_q [$];
  logic [63:0] addr_q [$];
  logic [31:0] data_q [$];
  logic [31:0] mem [logic [63:0]];

  bit          pend = 0;
  int          pend_cnt = 0;
  logic        pend_err = 1'b0;
  logic [31:0] pend_data = '0;
  int          wait_cnt = 0;
  int          slave_idx = 0;
  logic [63:0] hold_addr = '0;
  logic [31:0] hold_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_keys();
    for (int k = 0; k < NK; k++)
      for (int w = 0; w < KW; w++) begin
        keys[k][w] = $urandom;
        key_data_i[(k*KW+w)*32 +: 32] = keys[k][w];
      end
  endtask

  // Bus responder: grants after an optional wait, answers one cycle (+delay) later.
  initial begin
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
      if (!rst_ni) begin
        pend = 0;
        wait_cnt = 0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            bus_rvalid_i = 1'b1; bus_err_i = pend_err; bus_rdata_i = pend_data; pend = 0;
          end else begin
            pend_cnt--;
          end
        end
        if (bus_req_o) begin
          slave_idx = addr_q.size();
          if (slave_idx == gnt_wait_txn && wait_cnt < gnt_wait_cycles) begin
            if (wait_cnt == 0) begin
              hold_addr = bus_addr_o;
              hold_data = bus_wdata_o;
            end else begin
              check("hold_addr", bus_addr_o, hold_addr);
              check("hold_wdata", {32'h0, bus_wdata_o}, {32'h0, hold_data});
            end
            wait_cnt++;
          end else begin
            if (slave_idx == gnt_wait_txn && gnt_wait_cycles > 0) begin
              check("hold_addr_gnt", bus_addr_o, hold_addr);
              check("hold_wdata_gnt", {32'h0, bus_wdata_o}, {32'h0, hold_data});
            end
            bus_gnt_i = 1'b1;
            wait_cnt = 0;
            check("be", {60'h0, bus_be_o}, 64'hF);
            we_q.push_back(bus_we_o);
            addr_q.push_back(bus_addr_o);
            data_q.push_back(bus_wdata_o);
            if (bus_we_o) mem[bus_addr_o] = bus_wdata_o;
            pend = 1;
            pend_cnt = resp_delay;
            pend_err = (slave_idx == err_txn);
            if (bus_we_o) pend_data = '0;
            else pend_data = (mem.exists(bus_addr_o) ? mem[bus_addr_o] : 32'h0) ^
                             ((slave_idx == corrupt_txn) ? 32'h0000_0100 : 32'h0);
          end
        end
      end
    end
  end

  // One load: model derives transaction list and end cycle, then compares.
  task automatic run_load(input string tag, input logic [1:0] sel, input int wait_t, input int wait_c,
                          input int err_t, input int corrupt_t, input int delay,
                          input bit mid_change, input bit poke);
    int base, n, fail_t, exp_k, k, w;
    bit exp_done, seen_done, seen_err, timeout_mode, rd;
    logic [31:0] snap [KW];
    logic [63:0] exp_addr;
    base = addr_q.size();
    timeout_mode = (delay >= TO);
    fail_t = (err_t >= 0) ? err_t : (corrupt_t >= 0) ? corrupt_t : (timeout_mode ? 0 : -1);
    if (int'(sel) >= NK) n = 0;
    else if (fail_t < 0) n = KW * TPW;
    else n = fail_t + 1;
    exp_done = (int'(sel) < NK) && (fail_t < 0);
    exp_k = 0;
    for (int t = 0; t < n; t++) begin
      exp_k += 1 + ((t == wait_t) ? wait_c : 0);
      exp_k += timeout_mode ? TO : (1 + delay);
    end
    for (int i = 0; i < KW; i++) snap[i] = (int'(sel) < NK) ? keys[sel][i] : 32'h0;

    gnt_wait_txn    = (wait_t < 0) ? -1 : base + wait_t;
    gnt_wait_cycles = wait_c;
    err_txn         = (err_t < 0) ? -1 : base + err_t;
    corrupt_txn     = (corrupt_t < 0) ? -1 : base + corrupt_t;
    resp_delay      = delay;

    @(negedge clk_i);
    load_sel_i = sel;
    load_req_i = 1'b1;
    @(posedge clk_i);
    #1 load_req_i = 1'b0;
    seen_done = 0; seen_err = 0; k = 0;
    while (k < 4000) begin
      @(negedge clk_i);
      if (k == 0) check({tag, " busy"}, {63'h0, busy_o}, {63'h0, (n > 0)});
      if (done_o || err_o) begin
        seen_done = done_o;
        seen_err = err_o;
        break;
      end
      if (mid_change && k == 3) fill_keys();
      if (poke && k == 2) begin
        load_sel_i = sel ^ 2'b01;
        load_req_i = 1'b1;
      end else begin
        load_req_i = 1'b0;
      end
      k++;
    end
    check({tag, " end_cycle"}, 64'(k), 64'(exp_k));
    check({tag, " done"}, {63'h0, seen_done}, {63'h0, exp_done});
    check({tag, " err"}, {63'h0, seen_err}, {63'h0, !exp_done});
    if (poke) begin
      load_sel_i = sel;
      load_req_i = 1'b1;
    end
    @(negedge clk_i);
    load_req_i = 1'b0;
    check({tag, " pulse_end"}, {61'h0, done_o, err_o, busy_o}, 64'h0);
    check({tag, " txn_count"}, 64'(addr_q.size() - base), 64'(n));
    for (int t = 0; t < n && t < addr_q.size() - base; t++) begin
      w = t / TPW;
      rd = ((t % TPW) == 1);
      exp_addr = AES_BASE + 64'(4 * slot_off[sel]) + 64'(4 * w);
      check({tag, " addr"}, addr_q[base+t], exp_addr);
      check({tag, " we"}, {63'h0, we_q[base+t]}, {63'h0, !rd});
      if (!rd) check({tag, " wdata"}, {32'h0, data_q[base+t]}, {32'h0, snap[w]});
    end
    $display("load %s sel=%0d txns=%0d cycles=%0d done=%0d err=%0d", tag, sel, n, k, seen_done, seen_err);
    gnt_wait_txn = -1; gnt_wait_cycles = 0; err_txn = -1; corrupt_txn = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int log0;
    bit seen;
    fill_keys();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst outputs", {bus_req_o, busy_o, done_o, err_o, bus_we_o, bus_be_o}, 64'h0);
    check("rst addr", bus_addr_o, 64'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle outputs", {bus_req_o, busy_o, done_o, err_o}, 64'h0);

    run_load("t1_slot0", 2'd0, -1, 0, -1, -1, 0, 1'b0, 1'b0);
    run_load("t2_slot2_gntwait", 2'd2, 3*TPW, 5, -1, -1, 0, 1'b0, 1'b0);
    run_load("t3_bad_sel", 2'd3, -1, 0, -1, -1, 0, 1'b0, 1'b0);
    run_load("t4_err_w2", 2'd1, -1, 0, 2*TPW, -1, 0, 1'b0, 1'b0);
    run_load("t4_reload", 2'd1, -1, 0, -1, -1, 0, 1'b0, 1'b0);

    run_load("t5_timeout", 2'd0, -1, 0, -1, -1, 300, 1'b0, 1'b0);
    seen = 0;
    for (int c = 0; c < 400 && pend; c++) begin
      @(negedge clk_i);
      if (done_o) seen = 1;
    end
    @(negedge clk_i);
    if (done_o) seen = 1;
    check("t5 late_rvalid_done", {63'h0, seen}, 64'h0);
    check("t5 late_drained", {63'h0, pend}, 64'h0);
    check("t5 idle_after_late", {62'h0, busy_o, bus_req_o}, 64'h0);
    resp_delay = 0;

    fill_keys();
    run_load("t5_snapshot_poke", 2'd2, -1, 0, -1, -1, 0, 1'b1, 1'b1);

    for (int i = 0; i < 4; i++) begin
      fill_keys();
      run_load("rnd", 2'($urandom_range(0, 2)), $urandom_range(0, KW*TPW-1), $urandom_range(0, 4),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, KW*TPW-1)) : -1,
               -1, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    // async reset while a request is held waiting for grant
    gnt_wait_txn = addr_q.size();
    gnt_wait_cycles = 50;
    @(negedge clk_i);
    load_sel_i = 2'd0; load_req_i = 1'b1;
    @(posedge clk_i);
    #1 load_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("t6 req_held", {63'h0, bus_req_o}, 64'h1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6 req_drop", {61'h0, bus_req_o, busy_o, done_o}, 64'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    gnt_wait_txn = -1; gnt_wait_cycles = 0;

    // async reset while waiting for the response
    resp_delay = 20;
    log0 = addr_q.size();
    @(negedge clk_i);
    load_sel_i = 2'd1; load_req_i = 1'b1;
    @(posedge clk_i);
    #1 load_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("t6 busy_resp", {62'h0, busy_o, bus_req_o}, 64'h2);
    #2 rst_ni = 1'b0;
    #1;
    check("t6 resp_drop", {61'h0, bus_req_o, busy_o, done_o}, 64'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    resp_delay = 0;
    repeat (5) @(negedge clk_i);
    check("t6 no_retry", 64'(addr_q.size() - log0), 64'd1);
    run_load("t6_recover", 2'd2, -1, 0, -1, -1, 0, 1'b0, 1'b0);

`ifdef AES_KEY_LOADER_READBACK_EN
    run_load("t6_rb_mismatch_w1", 2'd1, -1, 0, -1, 1*TPW+1, 0, 1'b0, 1'b0);
    run_load("t6_rb_clean", 2'd0, -1, 0, -1, -1, 1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
